// File: rtl/flt_norm_round_pipe.sv
// rtl/flt_norm_round_pipe.sv - two-stage normalise / RNE-round / saturate stage for 1x32b, 2x16b or 4x8b adder lanes.
// Optional FLT_NORM_OVF_CNT_EN adds a saturating ovf_cnt output and its ovf_cnt_clr input.
module flt_norm_round_lane #(
  parameter int MANT_L  = 24,
  parameter int EXP_L   = 8,
  parameter int EXP_MAX = 255
) (
  input  logic [MANT_L+1:0] mant_in,
  input  logic [EXP_L:0]    exp_in,
  output logic [MANT_L-1:0] mant_out,
  output logic [EXP_L:0]    exp_out,
  output logic              ovf
);
  localparam int EW = EXP_L + 2;
  localparam logic signed [EW-1:0] EMAX = EW'(EXP_MAX);

  logic [MANT_L-1:0]    m;
  logic                 guard, sticky, up;
  logic signed [EW-1:0] e;

  always_comb begin
    e      = {exp_in[EXP_L], exp_in};
    m      = mant_in[MANT_L:1];
    guard  = mant_in[0];
    sticky = 1'b0;
    ovf    = 1'b0;
    if (mant_in[MANT_L+1]) begin
      m      = mant_in[MANT_L+1:2];
      guard  = mant_in[1];
      sticky = mant_in[0];
      e      = e + EW'(1);
    end
    up = guard && (sticky || m[0]);
    if (up) begin
      if (&m) begin
        m = {1'b1, {(MANT_L-1){1'b0}}};
        e = e + EW'(1);
      end else begin
        m = m + MANT_L'(1);
      end
    end
    if (mant_in == '0) begin
      m = '0;
      e = '0;
    end else if (e > EMAX) begin
      e   = EMAX;
      m   = '1;
      ovf = 1'b1;
    end
    mant_out = m;
    exp_out  = e[EXP_L:0];
  end
endmodule

module flt_norm_round_pipe #(
  parameter int PRECISION_CONFIG_L   = 2,
  parameter int EXP_COMBINED_FULL_L  = 8,
  parameter int EXP_COMBINED_HALF_L  = 5,
  parameter int EXP_COMBINED_QUART_L = 4,
  parameter int MANT_FULL_L          = 24,
  parameter int MANT_HALF_L          = 11,
  parameter int MANT_QUART_L         = 4,
  parameter int EXP_MAX_FULL         = (2**EXP_COMBINED_FULL_L)-1,
  parameter int EXP_MAX_HALF         = (2**EXP_COMBINED_HALF_L)-1,
  parameter int EXP_MAX_QUART        = (2**EXP_COMBINED_QUART_L)-1,
  parameter logic [PRECISION_CONFIG_L-1:0] MODE_32B = 0,
  parameter logic [PRECISION_CONFIG_L-1:0] MODE_16B = 1,
  parameter logic [PRECISION_CONFIG_L-1:0] MODE_8B  = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [PRECISION_CONFIG_L-1:0]         mode,
  input  logic [EXP_COMBINED_FULL_L:0]          exp_full_in,
  input  logic [2*(EXP_COMBINED_HALF_L+1)-1:0]  exp_half_in,
  input  logic [4*(EXP_COMBINED_QUART_L+1)-1:0] exp_quart_in,
  input  logic [MANT_FULL_L+1:0]                mant_full_in,
  input  logic [2*(MANT_HALF_L+2)-1:0]          mant_half_in,
  input  logic [4*(MANT_QUART_L+2)-1:0]         mant_quart_in,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [PRECISION_CONFIG_L-1:0]         mode_out,
  output logic [EXP_COMBINED_FULL_L:0]          exp_full_out,
  output logic [2*(EXP_COMBINED_HALF_L+1)-1:0]  exp_half_out,
  output logic [4*(EXP_COMBINED_QUART_L+1)-1:0] exp_quart_out,
  output logic [MANT_FULL_L-1:0]                mant_full_out,
  output logic [2*MANT_HALF_L-1:0]              mant_half_out,
  output logic [4*MANT_QUART_L-1:0]             mant_quart_out,
  output logic [3:0]                            ovf_out
`ifdef FLT_NORM_OVF_CNT_EN
  ,
  input  logic                                  ovf_cnt_clr,
  output logic [15:0]                           ovf_cnt
`endif
);
  localparam int EHW = EXP_COMBINED_HALF_L + 1;
  localparam int EQW = EXP_COMBINED_QUART_L + 1;
  localparam int MHW = MANT_HALF_L + 2;
  localparam int MQW = MANT_QUART_L + 2;

  logic                                  s1_valid;
  logic [PRECISION_CONFIG_L-1:0]         s1_mode;
  logic [EXP_COMBINED_FULL_L:0]          s1_exp_full;
  logic [2*EHW-1:0]                      s1_exp_half;
  logic [4*EQW-1:0]                      s1_exp_quart;
  logic [MANT_FULL_L+1:0]                s1_mant_full;
  logic [2*MHW-1:0]                      s1_mant_half;
  logic [4*MQW-1:0]                      s1_mant_quart;
  logic                                  s1_adv, s2_adv;

  logic [EXP_COMBINED_FULL_L:0]          n_exp_full;
  logic [2*EHW-1:0]                      n_exp_half;
  logic [4*EQW-1:0]                      n_exp_quart;
  logic [MANT_FULL_L-1:0]                n_mant_full;
  logic [2*MANT_HALF_L-1:0]              n_mant_half;
  logic [4*MANT_QUART_L-1:0]             n_mant_quart;
  logic                                  n_ovf_full;
  logic [1:0]                            n_ovf_half;
  logic [3:0]                            n_ovf_quart;
  logic                                  full_act, half_act, quart_act;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      s1_mode       <= '0;
      s1_exp_full   <= '0;
      s1_exp_half   <= '0;
      s1_exp_quart  <= '0;
      s1_mant_full  <= '0;
      s1_mant_half  <= '0;
      s1_mant_quart <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode       <= mode;
        s1_exp_full   <= exp_full_in;
        s1_exp_half   <= exp_half_in;
        s1_exp_quart  <= exp_quart_in;
        s1_mant_full  <= mant_full_in;
        s1_mant_half  <= mant_half_in;
        s1_mant_quart <= mant_quart_in;
      end
    end
  end

  flt_norm_round_lane #(.MANT_L(MANT_FULL_L), .EXP_L(EXP_COMBINED_FULL_L), .EXP_MAX(EXP_MAX_FULL)) u_full (
    .mant_in(s1_mant_full), .exp_in(s1_exp_full),
    .mant_out(n_mant_full), .exp_out(n_exp_full), .ovf(n_ovf_full)
  );

  for (genvar i = 0; i < 2; i++) begin : g_half
    flt_norm_round_lane #(.MANT_L(MANT_HALF_L), .EXP_L(EXP_COMBINED_HALF_L), .EXP_MAX(EXP_MAX_HALF)) u_lane (
      .mant_in(s1_mant_half[i*MHW +: MHW]), .exp_in(s1_exp_half[i*EHW +: EHW]),
      .mant_out(n_mant_half[i*MANT_HALF_L +: MANT_HALF_L]), .exp_out(n_exp_half[i*EHW +: EHW]),
      .ovf(n_ovf_half[i])
    );
  end

  for (genvar i = 0; i < 4; i++) begin : g_quart
    flt_norm_round_lane #(.MANT_L(MANT_QUART_L), .EXP_L(EXP_COMBINED_QUART_L), .EXP_MAX(EXP_MAX_QUART)) u_lane (
      .mant_in(s1_mant_quart[i*MQW +: MQW]), .exp_in(s1_exp_quart[i*EQW +: EQW]),
      .mant_out(n_mant_quart[i*MANT_QUART_L +: MANT_QUART_L]), .exp_out(n_exp_quart[i*EQW +: EQW]),
      .ovf(n_ovf_quart[i])
    );
  end

  assign full_act  = (s1_mode == MODE_32B);
  assign half_act  = (s1_mode == MODE_16B);
  assign quart_act = (s1_mode == MODE_8B);

  // Lanes not used by the beat's mode are forced to zero so the writeback sees clean fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      mode_out       <= '0;
      exp_full_out   <= '0;
      exp_half_out   <= '0;
      exp_quart_out  <= '0;
      mant_full_out  <= '0;
      mant_half_out  <= '0;
      mant_quart_out <= '0;
      ovf_out        <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        mode_out       <= s1_mode;
        exp_full_out   <= full_act  ? n_exp_full   : '0;
        mant_full_out  <= full_act  ? n_mant_full  : '0;
        exp_half_out   <= half_act  ? n_exp_half   : '0;
        mant_half_out  <= half_act  ? n_mant_half  : '0;
        exp_quart_out  <= quart_act ? n_exp_quart  : '0;
        mant_quart_out <= quart_act ? n_mant_quart : '0;
        ovf_out        <= full_act  ? {3'b000, n_ovf_full} :
                          half_act  ? {2'b00, n_ovf_half}  :
                          quart_act ? n_ovf_quart          : 4'b0000;
      end
    end
  end

`ifdef FLT_NORM_OVF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (ovf_cnt_clr) begin
      ovf_cnt <= '0;
    end else if (out_valid && out_ready && (|ovf_out) && (ovf_cnt != 16'hFFFF)) begin
      ovf_cnt <= ovf_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_flt_norm_round_pipe.sv
// tb/tb_flt_norm_round_pipe.sv - scoreboard bench for flt_norm_round_pipe (default widths 32/16/8, optional FLT_NORM_OVF_CNT_EN).
module tb_flt_norm_round_pipe;
  localparam logic [1:0] M32 = 2'd0, M16 = 2'd1, M8 = 2'd2;

  typedef struct {
    logic [1:0]  mode;
    logic [8:0]  ef;
    logic [11:0] eh;
    logic [19:0] eq;
    logic [25:0] mf;
    logic [25:0] mh;
    logic [23:0] mq;
  } beat_t;

  typedef struct {
    logic [1:0]  mode;
    logic [8:0]  ef;
    logic [11:0] eh;
    logic [19:0] eq;
    logic [23:0] mf;
    logic [21:0] mh;
    logic [15:0] mq;
    logic [3:0]  ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  mode, mode_out;
  logic [8:0]  exp_full_in, exp_full_out;
  logic [11:0] exp_half_in, exp_half_out;
  logic [19:0] exp_quart_in, exp_quart_out;
  logic [25:0] mant_full_in, mant_half_in;
  logic [23:0] mant_quart_in, mant_full_out;
  logic [21:0] mant_half_out;
  logic [15:0] mant_quart_out;
  logic [3:0]  ovf_out;
`ifdef FLT_NORM_OVF_CNT_EN
  logic        ovf_cnt_clr = 1'b0;
  logic [15:0] ovf_cnt;
`endif

  int   n_asrt = 0, n_fail = 0, ovf_beats = 0;
  bit   rnd_bp = 0;
  res_t sb[$];

  flt_norm_round_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .exp_full_in(exp_full_in), .exp_half_in(exp_half_in), .exp_quart_in(exp_quart_in),
    .mant_full_in(mant_full_in), .mant_half_in(mant_half_in), .mant_quart_in(mant_quart_in),
    .out_valid(out_valid), .out_ready(out_ready), .mode_out(mode_out),
    .exp_full_out(exp_full_out), .exp_half_out(exp_half_out), .exp_quart_out(exp_quart_out),
    .mant_full_out(mant_full_out), .mant_half_out(mant_half_out), .mant_quart_out(mant_quart_out),
    .ovf_out(ovf_out)
`ifdef FLT_NORM_OVF_CNT_EN
    , .ovf_cnt_clr(ovf_cnt_clr), .ovf_cnt(ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Rounding expressed as remainder-vs-half comparison on the integer mantissa.
  function automatic void lane_m(input int ml, input int el, input longint mi, input longint ei,
                                 output longint mo, output longint eo, output logic ov);
    longint e, kept, rem, half, emax;
    int     s;
    e = ei;
    if (e >= (longint'(1) << el)) e -= (longint'(1) << (el + 1));
    emax = (longint'(1) << el) - 1;
    ov   = 1'b0;
    if (mi == 0) begin
      mo = 0; eo = 0;
      return;
    end
    s    = (((mi >> (ml + 1)) & 1) != 0) ? 2 : 1;
    kept = mi >> s;
    rem  = mi & ((longint'(1) << s) - 1);
    half = longint'(1) << (s - 1);
    e   += s - 1;
    if (rem > half || (rem == half && (kept & 1) != 0)) kept++;
    if (kept >= (longint'(1) << ml)) begin
      kept >>= 1;
      e++;
    end
    if (e > emax) begin
      e = emax; kept = (longint'(1) << ml) - 1; ov = 1'b1;
    end
    mo = kept;
    eo = e & ((longint'(1) << (el + 1)) - 1);
  endfunction

  function automatic res_t model(input beat_t b);
    res_t   r;
    longint mo, eo;
    logic   ov;
    r = '{mode: b.mode, ef: '0, eh: '0, eq: '0, mf: '0, mh: '0, mq: '0, ovf: '0};
    if (b.mode == M32) begin
      lane_m(24, 8, longint'(b.mf), longint'(b.ef), mo, eo, ov);
      r.mf = 24'(mo); r.ef = 9'(eo); r.ovf[0] = ov;
    end else if (b.mode == M16) begin
      for (int i = 0; i < 2; i++) begin
        lane_m(11, 5, longint'(b.mh[i*13 +: 13]), longint'(b.eh[i*6 +: 6]), mo, eo, ov);
        r.mh[i*11 +: 11] = 11'(mo); r.eh[i*6 +: 6] = 6'(eo); r.ovf[i] = ov;
      end
    end else if (b.mode == M8) begin
      for (int i = 0; i < 4; i++) begin
        lane_m(4, 4, longint'(b.mq[i*6 +: 6]), longint'(b.eq[i*5 +: 5]), mo, eo, ov);
        r.mq[i*4 +: 4] = 4'(mo); r.eq[i*5 +: 5] = 5'(eo); r.ovf[i] = ov;
      end
    end
    return r;
  endfunction

  function automatic beat_t cur_beat();
    return '{mode: mode, ef: exp_full_in, eh: exp_half_in, eq: exp_quart_in,
             mf: mant_full_in, mh: mant_half_in, mq: mant_quart_in};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) sb.push_back(model(cur_beat()));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_unexpected_beat", 64'd1, 64'd0);
        else begin
          res_t r;
          r = sb.pop_front();
          if (r.ovf != 0) ovf_beats++;
          chk("mode_out", 64'(mode_out), 64'(r.mode));
          chk("exp_full", 64'(exp_full_out), 64'(r.ef));
          chk("mant_full", 64'(mant_full_out), 64'(r.mf));
          chk("exp_half", 64'(exp_half_out), 64'(r.eh));
          chk("mant_half", 64'(mant_half_out), 64'(r.mh));
          chk("exp_quart", 64'(exp_quart_out), 64'(r.eq));
          chk("mant_quart", 64'(mant_quart_out), 64'(r.mq));
          chk("ovf_out", 64'(ovf_out), 64'(r.ovf));
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic drive(input beat_t b);
    in_valid = 1'b1; mode = b.mode;
    exp_full_in = b.ef; exp_half_in = b.eh; exp_quart_in = b.eq;
    mant_full_in = b.mf; mant_half_in = b.mh; mant_quart_in = b.mq;
  endtask

  task automatic send(input beat_t b);
    bit ok = 0;
    drive(b);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    chk("send_timeout", 64'(ok), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  function automatic beat_t mk(input logic [1:0] md, input logic [8:0] ef, input logic [25:0] mf,
                               input logic [11:0] eh, input logic [25:0] mh,
                               input logic [19:0] eq, input logic [23:0] mq);
    return '{mode: md, ef: ef, eh: eh, eq: eq, mf: mf, mh: mh, mq: mq};
  endfunction

  function automatic longint rexp(input int el);
    longint emax = (longint'(1) << el) - 1;
    if ($urandom_range(0, 2) == 0) return emax - longint'($urandom_range(0, 2));
    return longint'($urandom) & ((longint'(1) << (el + 1)) - 1);
  endfunction

  function automatic longint rmant(input int ml);
    if ($urandom_range(0, 7) == 0) return 0;
    if ($urandom_range(0, 5) == 0) return (longint'(1) << (ml + 1)) - 1;
    return {$urandom, $urandom} & ((longint'(1) << (ml + 2)) - 1);
  endfunction

  function automatic beat_t rnd_beat();
    beat_t b;
    b.mode = 2'($urandom_range(0, 2));
    b.ef = 9'(rexp(8));
    b.mf = 26'(rmant(24));
    for (int i = 0; i < 2; i++) begin
      b.eh[i*6 +: 6] = 6'(rexp(5)); b.mh[i*13 +: 13] = 13'(rmant(11));
    end
    for (int i = 0; i < 4; i++) begin
      b.eq[i*5 +: 5] = 5'(rexp(4)); b.mq[i*6 +: 6] = 6'(rmant(4));
    end
    return b;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst_n = 1'b0; out_ready = 1'b1;
    drive(mk(M32, '0, '0, '0, '0, '0, '0)); in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mode_out", 64'(mode_out), 64'd0);
    chk("rst_exp_full", 64'(exp_full_out), 64'd0);
    chk("rst_mant_full", 64'(mant_full_out), 64'd0);
    chk("rst_ovf", 64'(ovf_out), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Hidden one in place, no rounding, two-cycle latency.
    send(mk(M32, 9'd5, {1'b0, 1'b1, 23'd0, 1'b0}, '0, '0, '0, '0));
    idle();
    @(negedge clk); chk("lat_not_early", 64'(out_valid), 64'd0);
    @(negedge clk); chk("lat_valid", 64'(out_valid), 64'd1);
    chk("t1_mant", 64'(mant_full_out), 64'h800000);
    chk("t1_exp", 64'(exp_full_out), 64'd5);
    chk("t1_ovf", 64'(ovf_out), 64'd0);
    @(posedge clk); #1;

    // Carry-out, guard set, sticky clear, even lsb: no round-up.
    send(mk(M32, 9'd3, {2'b11, 22'd0, 2'b10}, '0, '0, '0, '0));
    idle();
    repeat (2) @(negedge clk);
    chk("t2_mant", 64'(mant_full_out), 64'hC00000);
    chk("t2_exp", 64'(exp_full_out), 64'd4);
    @(posedge clk); #1;

    // 8b lane 2 rounds past the top exponent and saturates.
    send(mk(M8, '0, '0, '0, '0, {5'd1, 5'd15, 5'd1, 5'd1},
            {6'b010000, 6'b011111, 6'b010000, 6'b010000}));
    idle();
    repeat (2) @(negedge clk);
    chk("t3_ovf", 64'(ovf_out), 64'b0100);
    chk("t3_mant", 64'(mant_quart_out), 64'h8F88);
    chk("t3_exp", 64'(exp_quart_out), 64'({5'd1, 5'd15, 5'd1, 5'd1}));
    chk("t3_full_zero", 64'(mant_full_out), 64'd0);
    @(posedge clk); #1;

    // 16b zero lane beside a rounding lane, then an 8b beat with no bubble.
    send(mk(M16, 9'd7, 26'h3FFFFFF, {6'd9, 6'd7}, {13'b0100000000011, 13'd0}, '0, '0));
    send(mk(M8, '0, '0, '0, '0, {5'd2, 5'd3, 5'd4, 5'd5},
            {6'b100001, 6'b010001, 6'b011110, 6'b010011}));
    idle();
    @(negedge clk);
    chk("t4_mode16", 64'(mode_out), 64'(M16));
    chk("t4_mant_half", 64'(mant_half_out), 64'({11'b10000000010, 11'd0}));
    chk("t4_exp_half", 64'(exp_half_out), 64'({6'd9, 6'd0}));
    chk("t4_full_gated", 64'(exp_full_out), 64'd0);
    @(negedge clk);
    chk("t4_valid8", 64'(out_valid), 64'd1);
    chk("t4_mode8", 64'(mode_out), 64'(M8));
    @(posedge clk); #1;

    // Stall: two beats held, third refused until release.
    out_ready = 1'b0;
    send(mk(M32, 9'd10, {2'b01, 24'h000011}, '0, '0, '0, '0));
    send(mk(M32, 9'd11, {2'b01, 24'h000022}, '0, '0, '0, '0));
    drive(mk(M32, 9'd12, {2'b01, 24'h000033}, '0, '0, '0, '0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_hold", 64'(mant_full_out), 64'(sb[0].mf));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(mk(M32, 9'd12, {2'b01, 24'h000033}, '0, '0, '0, '0));
    idle();

    // Random traffic under random backpressure.
    rnd_bp = 1;
    for (int i = 0; i < 60; i++) send(rnd_beat());
    idle();
    rnd_bp = 0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin ok = 1; break; end
    end
    chk("drain_random", 64'(ok), 64'd1);
    @(posedge clk); #1;

`ifdef FLT_NORM_OVF_CNT_EN
    chk("ovf_cnt", 64'(ovf_cnt), 64'(ovf_beats));
`endif

    // Reset with two beats in flight discards them.
    send(mk(M32, 9'd20, {2'b01, 24'h000044}, '0, '0, '0, '0));
    send(mk(M32, 9'd21, {2'b01, 24'h000055}, '0, '0, '0, '0));
    idle();
    rst_n = 1'b0;
    sb.delete();
    ovf_beats = 0;
    #1;
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    send(mk(M32, 9'd6, {2'b01, 24'h000001, 1'b1} >> 1, '0, '0, '0, '0));
    idle();
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin ok = 1; break; end
    end
    chk("drain_after_reset", 64'(ok), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
